fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 249 ++++++++++++++++++++++++
 tb/tb_fetch_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//
// Purpose:
//   Instruction fetch unit for a simple in-order core. It keeps the program
//   counter and issues one word-aligned request at a time to instruction
//   memory. The returned word is held in a registered output together with
//   its address and a one-hot instruction class until the control unit
//   consumes it. Redirects from execute have the highest priority. If a
//   redirect arrives while a request is still outstanding, the late response
//   is absorbed in DRAIN so that it never reaches the control unit.
//
// Parameters:
//   RESET_PC        PC loaded on reset. Bits [1:0] are ignored, so the
//                   address is always word-aligned.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   imem_req        fetch request, high only in REQ
//   imem_addr       word-aligned fetch address, valid while imem_req=1
//   imem_ready      memory accepts the request this cycle
//   imem_rvalid     read data valid, one pulse per accepted request
//   imem_rdata      instruction word from memory
//   redirect_valid  branch/jump redirect from execute
//   redirect_pc     redirect target, bits [1:0] are forced to 0
//   stall           downstream cannot consume the held instruction
//   instr           registered instruction word
//   pc_out          address of instr
//   dec             registered one-hot instruction class
//                   [8] R-type  [7] I-ALU  [6] load  [5] store  [4] branch
//                   [3] JAL     [2] JALR   [1] LUI   [0] AUIPC
//                   For an unknown opcode, dec is 0.
//   instr_valid     instr / pc_out / dec are valid
//   illegal         only when FETCH_ILLEGAL_DETECT_EN is defined.
//                   1 when the held instruction has an unknown opcode.
//
// Configuration macro:
//   FETCH_ILLEGAL_DETECT_EN  adds the registered 'illegal' output.
// ----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [8:0]  dec,
`ifdef FETCH_ILLEGAL_DETECT_EN
  output logic        illegal,
`endif
  output logic        instr_valid
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  // Opcode values from the base integer ISA.
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic [31:0] pc_reg;
  logic [31:0] instr_reg;
  logic [31:0] pc_out_reg;
  logic [8:0]  dec_reg;
  logic        instr_valid_reg;

  // Strobes produced by the FSM and used by the datapath.
  logic        capture;     // latch the returned word into the output registers
  logic        release_out; // the held instruction leaves (consumed or flushed)
  logic [8:0]  dec_next;

  // Map the opcode to a one-hot class. Any unknown opcode gives 0.
  function automatic logic [8:0] decode_class(input logic [6:0] opcode);
    logic [8:0] cls;
    cls = 9'b0;
    case (opcode)
      OP_R_TYPE: cls = 9'b1_0000_0000;
      OP_I_ALU:  cls = 9'b0_1000_0000;
      OP_LOAD:   cls = 9'b0_0100_0000;
      OP_STORE:  cls = 9'b0_0010_0000;
      OP_BRANCH: cls = 9'b0_0001_0000;
      OP_JAL:    cls = 9'b0_0000_1000;
      OP_JALR:   cls = 9'b0_0000_0100;
      OP_LUI:    cls = 9'b0_0000_0010;
      OP_AUIPC:  cls = 9'b0_0000_0001;
      default:   cls = 9'b0;
    endcase
    return cls;
  endfunction

  assign dec_next = decode_class(imem_rdata[6:0]);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and control outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    imem_req    = 1'b0;
    imem_addr   = 32'h0;
    capture     = 1'b0;
    release_out = redirect_valid;

    case (state_reg)
      IDLE: begin
        // A redirect here only moves the PC. REQ follows in either case.
        state_next = REQ;
      end

      REQ: begin
        imem_req  = 1'b1;
        imem_addr = pc_reg;
        if (redirect_valid) begin
          // If the request was accepted in the same cycle, its response is
          // still on its way and must be discarded.
          state_next = imem_ready ? DRAIN : REQ;
        end else if (imem_ready) begin
          state_next = WAIT;
        end
      end

      WAIT: begin
        if (redirect_valid) begin
          // A response that arrives together with the redirect is dropped
          // here. Otherwise, the response that is still expected is
          // absorbed in DRAIN.
          state_next = imem_rvalid ? REQ : DRAIN;
        end else if (imem_rvalid) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          state_next = REQ;
        end else if (!stall) begin
          release_out = 1'b1;
          state_next  = REQ;
        end
      end

      DRAIN: begin
        // Only the response of the outstanding request ends DRAIN. A further
        // redirect just moves the PC.
        if (imem_rvalid) begin
          state_next = REQ;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // PC and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg          <= RESET_PC_ALIGNED;
      instr_reg       <= 32'h0;
      pc_out_reg      <= 32'h0;
      dec_reg         <= 9'h0;
      instr_valid_reg <= 1'b0;
    end else begin
      // A redirect takes priority over the sequential increment.
      // The increment wraps naturally at 2^32.
      if (redirect_valid) begin
        pc_reg <= redirect_pc & 32'hFFFF_FFFC;
      end else if (capture) begin
        pc_reg <= pc_reg + 32'd4;
      end

      if (capture) begin
        instr_reg  <= imem_rdata;
        pc_out_reg <= pc_reg;
        dec_reg    <= dec_next;
      end

      if (capture) begin
        instr_valid_reg <= 1'b1;
      end else if (release_out) begin
        instr_valid_reg <= 1'b0;
      end
    end
  end

`ifdef FETCH_ILLEGAL_DETECT_EN
  logic illegal_reg;

  // Updated together with instr_valid. This keeps the flag equal to
  // (dec == 0) & instr_valid without extra combinational logic on the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_reg <= 1'b0;
    end else if (capture) begin
      illegal_reg <= (dec_next == 9'h0);
    end else if (release_out) begin
      illegal_reg <= 1'b0;
    end
  end

  assign illegal = illegal_reg;
`endif

  assign instr       = instr_reg;
  assign pc_out      = pc_out_reg;
  assign dec         = dec_reg;
  assign instr_valid = instr_valid_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage with RESET_PC = 0. The bench plays the
// instruction memory itself. Each word that should reach the control unit is
// pushed to a scoreboard queue when it is driven on imem_rdata. A monitor pops
// and compares the queue entry when instr_valid rises. Redirect, drain,
// wrap-around and reset cases are checked directly against constants.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [8:0]  dec;
  logic        instr_valid;
`ifdef FETCH_ILLEGAL_DETECT_EN
  logic        illegal;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .instr          (instr),
    .pc_out         (pc_out),
    .dec            (dec),
`ifdef FETCH_ILLEGAL_DETECT_EN
    .illegal        (illegal),
`endif
    .instr_valid    (instr_valid)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic [8:0]  cls;
    logic        bad;
  } exp_t;

  exp_t sb_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: one compare set per instruction presented.
  logic prev_valid = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (instr_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected", sb_q.size(), 1);
      end else begin
        mon_e = sb_q.pop_front();
        $display("fetch pc=%h instr=%h dec=%b", pc_out, instr, dec);
        check_val("sb_pc_out", pc_out, mon_e.pc);
        check_val("sb_instr", instr, mon_e.word);
        check_val("sb_dec", 32'(dec), 32'(mon_e.cls));
`ifdef FETCH_ILLEGAL_DETECT_EN
        check_val("sb_illegal", 32'(illegal), 32'(mon_e.bad));
`endif
      end
    end
    prev_valid = instr_valid;
  end

  // One complete fetch. The task starts at a negedge with the DUT in REQ
  // (or about to enter it) and returns at the negedge after consumption.
  task automatic fetch_one(input logic [31:0] exp_pc, input logic [31:0] word,
                           input logic [8:0] exp_cls, input int ready_delay,
                           input int stall_cycles);
    int   guard;
    exp_t item;
    guard = 0;
    while (!imem_req && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_val("req_seen", 32'(imem_req), 1);
    check_val("fetch_addr", imem_addr, exp_pc);
    for (int i = 0; i < ready_delay; i++) begin
      @(negedge clk);
      check_val("req_hold", 32'(imem_req), 1);
      check_val("addr_hold", imem_addr, exp_pc);
    end
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    check_val("wait_no_req", 32'(imem_req), 0);
    item.pc   = exp_pc;
    item.word = word;
    item.cls  = exp_cls;
    item.bad  = (exp_cls == 9'h0);
    sb_q.push_back(item);
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check_val("captured", 32'(instr_valid), 1);
    for (int i = 0; i < stall_cycles; i++) begin
      stall = 1'b1;
      @(negedge clk);
      check_val("stall_valid", 32'(instr_valid), 1);
      check_val("stall_no_req", 32'(imem_req), 0);
      check_val("stall_dec", 32'(dec), 32'(exp_cls));
      check_val("stall_pc_out", pc_out, exp_pc);
    end
    stall = 1'b0;
    @(negedge clk);
    check_val("consumed", 32'(instr_valid), 0);
  endtask

  logic [31:0] tbl_word [4];
  logic [8:0]  tbl_cls  [4];
  exp_t        item_m;

  initial begin
    tbl_word[0] = 32'h0000_006F; tbl_cls[0] = 9'h008;  // JAL
    tbl_word[1] = 32'h0000_8067; tbl_cls[1] = 9'h004;  // JALR
    tbl_word[2] = 32'h0000_10B7; tbl_cls[2] = 9'h002;  // LUI
    tbl_word[3] = 32'h0000_1097; tbl_cls[3] = 9'h001;  // AUIPC

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_req", 32'(imem_req), 0);
    check_val("rst_addr", imem_addr, 0);
    check_val("rst_valid", 32'(instr_valid), 0);
    check_val("rst_instr", instr, 0);
    check_val("rst_pc_out", pc_out, 0);
    check_val("rst_dec", 32'(dec), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("req_after_idle", 32'(imem_req), 1);

    // Basic fetch, ready delay and long stall
    fetch_one(32'h0, 32'h0020_8133, 9'h100, 0, 0);   // R-type
    fetch_one(32'h4, 32'h0010_0093, 9'h080, 3, 0);   // I-ALU, ready low 3 cycles
    fetch_one(32'h8, 32'h0000_2083, 9'h040, 0, 5);   // lw, stall 5 cycles

    // Redirect in WAIT without rvalid -> DRAIN, late word dropped
    check_val("pre_drain_addr", imem_addr, 32'hC);
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    @(negedge clk);
    redirect_valid = 1'b0;
    check_val("drain_no_req", 32'(imem_req), 0);
    @(negedge clk);
    check_val("drain_no_req2", 32'(imem_req), 0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0033;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check_val("drain_drop", 32'(instr_valid), 0);
    check_val("drain_exit_req", 32'(imem_req), 1);
    check_val("drain_target", imem_addr, 32'h0000_0100);
    fetch_one(32'h100, 32'h0020_A023, 9'h020, 0, 0); // store

    // Redirect in REQ, accepted in the same cycle -> DRAIN
    imem_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    @(negedge clk);
    imem_ready     = 1'b0;
    redirect_valid = 1'b0;
    check_val("req_rd_drain", 32'(imem_req), 0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0013;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check_val("req_rd_drop", 32'(instr_valid), 0);
    check_val("req_rd_addr", imem_addr, 32'h0000_0200);

    // Redirect in HOLD wins over stall
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    item_m.pc = 32'h200; item_m.word = 32'h0020_8463; item_m.cls = 9'h010; item_m.bad = 1'b0;
    sb_q.push_back(item_m);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0020_8463;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check_val("hold_valid", 32'(instr_valid), 1);
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    @(negedge clk);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    check_val("hold_rd_flush", 32'(instr_valid), 0);
    check_val("hold_rd_req", 32'(imem_req), 1);
    check_val("hold_rd_addr", imem_addr, 32'h0000_0300);

    // Redirect in WAIT together with rvalid -> data dropped, back to REQ
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready     = 1'b0;
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'h0000_006F;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    @(negedge clk);
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    check_val("wait_rv_drop", 32'(instr_valid), 0);
    check_val("wait_rv_addr", imem_addr, 32'h0000_0400);

    // Remaining opcode classes, back-to-back
    for (int i = 0; i < 4; i++) begin
      fetch_one(32'h400 + 32'(4 * i), tbl_word[i], tbl_cls[i], 0, 0);
    end

    // PC wrap and unknown opcode. The redirect target has its low bits
    // set and must be aligned.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    fetch_one(32'hFFFF_FFFC, 32'hFFFF_FFFF, 9'h000, 0, 1);
    check_val("wrap_addr", imem_addr, 32'h0);

    // Reset while in WAIT. The late rvalid after release must be ignored.
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("midrst_req", 32'(imem_req), 0);
    check_val("midrst_valid", 32'(instr_valid), 0);
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0020_8133;
    rst_n       = 1'b1;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check_val("midrst_ignored", 32'(instr_valid), 0);
    check_val("midrst_req_on", 32'(imem_req), 1);
    check_val("midrst_addr", imem_addr, 32'h0);
    fetch_one(32'h0, 32'h0000_1097, 9'h001, 1, 1);

    check_val("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
